// File: rtl/img_pkg.sv
// Shared types and helpers for the windowed frame buffer and the image kernels that read it.
package img_pkg;

  typedef enum logic {
    PAD_ZERO      = 1'b0,
    PAD_REPLICATE = 1'b1
  } pad_mode_e;

  typedef enum logic {
    CLR_IDLE,
    CLR_ROW
  } clr_state_e;

  // Bit offset of window tap [wy][wx] inside the flattened window bus.
  function automatic int win_ofst(input int wy, input int wx,
                                  input int win_wd = 3, input int pxl_bits = 12);
    return (wy * win_wd + wx) * pxl_bits;
  endfunction

endpackage

// File: rtl/fb_win_tap.sv
// One window tap: centre coordinate plus a fixed offset, turned into an in-image index
// and a flag saying whether the storage value should be used at all.
module fb_win_tap
  import img_pkg::*;
#(
  parameter int COORD_BITS = 8,
  parameter int IMG_WD     = 4,
  parameter int IMG_HT     = 3,
  parameter int OFST_X     = 0,
  parameter int OFST_Y     = 0,
  parameter int PAD_MODE   = 0
) (
  input  logic [COORD_BITS-1:0] cx_i,
  input  logic [COORD_BITS-1:0] cy_i,
  output logic [COORD_BITS-1:0] tx_o,
  output logic [COORD_BITS-1:0] ty_o,
  output logic                  valid_o
);

  localparam int CW = COORD_BITS + 2;
  localparam logic signed [CW-1:0] OX_C  = CW'(OFST_X);
  localparam logic signed [CW-1:0] OY_C  = CW'(OFST_Y);
  localparam logic signed [CW-1:0] WD_C  = CW'(IMG_WD);
  localparam logic signed [CW-1:0] HT_C  = CW'(IMG_HT);
  localparam logic signed [CW-1:0] WDM_C = CW'(IMG_WD - 1);
  localparam logic signed [CW-1:0] HTM_C = CW'(IMG_HT - 1);

  logic signed [CW-1:0] tx, ty;
  logic signed [CW-1:0] clX, clY;
  logic                 inX, inY;

  // Two guard bits keep negative and past-the-edge taps distinguishable, so nothing wraps.
  assign tx = $signed({2'b00, cx_i}) + OX_C;
  assign ty = $signed({2'b00, cy_i}) + OY_C;

  always_comb begin
    inX = !tx[CW-1] && (tx < WD_C);
    inY = !ty[CW-1] && (ty < HT_C);
    if (tx[CW-1])        clX = '0;
    else if (tx >= WD_C) clX = WDM_C;
    else                 clX = tx;
    if (ty[CW-1])        clY = '0;
    else if (ty >= HT_C) clY = HTM_C;
    else                 clY = ty;
  end

  assign tx_o    = clX[COORD_BITS-1:0];
  assign ty_o    = clY[COORD_BITS-1:0];
  assign valid_o = (inX && inY) || (PAD_MODE == int'(PAD_REPLICATE));

endmodule

// File: rtl/frame_buf_win.sv
// Frame buffer with a combinational WIN_HT x WIN_WD neighbourhood read port,
// a single pixel write port and a row-per-cycle clear sequencer.
module frame_buf_win
  import img_pkg::*;
#(
  parameter int IMG_WD     = 4,
  parameter int IMG_HT     = 3,
  parameter int COORD_BITS = 8,
  parameter int WIN_WD     = 3,
  parameter int WIN_HT     = 3,
  parameter int PXL_BITS   = 12,
  parameter int PAD_MODE   = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clr,
  output logic                                clr_busy,
  input  logic                                wr_en,
  input  logic [COORD_BITS-1:0]               wr_x,
  input  logic [COORD_BITS-1:0]               wr_y,
  input  logic signed [PXL_BITS-1:0]          wr_data_pxl,
  input  logic                                rd_en,
  input  logic [COORD_BITS-1:0]               rd_x,
  input  logic [COORD_BITS-1:0]               rd_y,
  output logic [WIN_HT*WIN_WD*PXL_BITS-1:0]   rd_data_flat
);

  localparam logic [COORD_BITS-1:0] WD_C   = COORD_BITS'(IMG_WD);
  localparam logic [COORD_BITS-1:0] HT_C   = COORD_BITS'(IMG_HT);
  localparam logic [COORD_BITS-1:0] HTM1_C = COORD_BITS'(IMG_HT - 1);

  logic signed [PXL_BITS-1:0] pix_q [IMG_HT][IMG_WD];
  clr_state_e                 state_q;
  logic [COORD_BITS-1:0]      row_q, row_d;
  logic                       wrHit;

  assign clr_busy = (state_q == CLR_ROW);
  assign row_d    = row_q + 1'b1;
  assign wrHit    = wr_en && !clr_busy && (wr_x < WD_C) && (wr_y < HT_C);

  // The clear sweep owns storage while busy, so it takes priority over any write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR_IDLE;
      row_q   <= '0;
      for (int y = 0; y < IMG_HT; y++)
        for (int x = 0; x < IMG_WD; x++)
          pix_q[y][x] <= '0;
    end else begin
      case (state_q)
        CLR_IDLE: if (clr) begin
          state_q <= CLR_ROW;
          row_q   <= '0;
        end
        CLR_ROW: begin
          if (row_q == HTM1_C) state_q <= CLR_IDLE;
          else                 row_q   <= row_d;
        end
        default: state_q <= CLR_IDLE;
      endcase
      for (int y = 0; y < IMG_HT; y++)
        for (int x = 0; x < IMG_WD; x++)
          if (clr_busy && row_q == COORD_BITS'(y))
            pix_q[y][x] <= '0;
          else if (wrHit && wr_x == COORD_BITS'(x) && wr_y == COORD_BITS'(y))
            pix_q[y][x] <= wr_data_pxl;
    end
  end

  for (genvar wy = 0; wy < WIN_HT; wy++) begin : g_row
    for (genvar wx = 0; wx < WIN_WD; wx++) begin : g_tap
      logic [COORD_BITS-1:0]      tapX, tapY;
      logic                       tapVld;
      logic signed [PXL_BITS-1:0] tapPxl;

      fb_win_tap #(
        .COORD_BITS (COORD_BITS),
        .IMG_WD     (IMG_WD),
        .IMG_HT     (IMG_HT),
        .OFST_X     (wx - WIN_WD / 2),
        .OFST_Y     (wy - WIN_HT / 2),
        .PAD_MODE   (PAD_MODE)
      ) u_tap (
        .cx_i    (rd_x),
        .cy_i    (rd_y),
        .tx_o    (tapX),
        .ty_o    (tapY),
        .valid_o (tapVld)
      );

      always_comb begin
        tapPxl = '0;
        for (int y = 0; y < IMG_HT; y++)
          for (int x = 0; x < IMG_WD; x++)
            if (tapVld && tapX == COORD_BITS'(x) && tapY == COORD_BITS'(y))
              tapPxl = pix_q[y][x];
      end

      assign rd_data_flat[win_ofst(wy, wx, WIN_WD, PXL_BITS) +: PXL_BITS] =
        rd_en ? tapPxl : '0;
    end
  end

endmodule
